// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- types and constants shared by the CPU-side RAM model.
//   word_t      : 32-bit data/address word
//   ramstate_t  : FREE / BUSY / ACCESS / ERROR status reported to the requester
//   RAM_LAT_MAX : largest latency the 4-bit access counter can express
//   lat_legal() : range check used for elaboration-time parameter validation
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int RAM_LAT_MAX = 15;
  localparam int RAM_CNT_W   = 4;

  typedef logic [RAM_CNT_W-1:0] ram_cnt_t;

  function automatic logic lat_legal(input int lat);
    return (lat >= 1) && (lat <= RAM_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if -- request/response bundle between a CPU and the RAM model.
//   ramREN, ramWEN : read / write request, held by the master until ACCESS
//   ramaddr        : byte address
//   ramstore       : write data
//   ramload        : read data, valid only while ramstate == ACCESS
//   ramstate       : FREE / BUSY / ACCESS / ERROR
// Modports: master (CPU side), slave (RAM side).
interface ram_access_ctrl_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

endinterface

// File: rtl/ram_word_array.sv
// ram_word_array -- 2^ADDR_W x 32-bit storage.
//   clk   : write clock
//   we    : write enable, commits wdata to mem[waddr] at the rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index (combinational read)
//   rdata : mem[raddr], reflects contents before any write on the same edge
// Contents are deliberately not reset.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rdata
);

  word_t mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl -- fixed-latency RAM model with a FREE/BUSY/ACCESS/ERROR
// handshake. A held request sees LAT-1 BUSY cycles then one ACCESS cycle;
// writes commit at the edge closing ACCESS.
//
// Ports:
//   CLK    : clock, all state updates on the rising edge
//   RST    : synchronous active-high reset (memory contents are kept)
//   ram_if : slave side of ram_access_ctrl_if
// Parameters:
//   LAT    : request-to-ACCESS latency in cycles, 1..RAM_LAT_MAX
//   ADDR_W : word-index width, depth 2^ADDR_W words
// Build option:
//   RAM_ERROR_CHECK_EN : when defined, misaligned or out-of-range byte
//                        addresses report ERROR instead of aliasing.
//
// state  | meaning
// FREE   | no request, or RST asserted
// BUSY   | request counting towards LAT-1
// ACCESS | data phase; read data valid, write commits at end of cycle
// ERROR  | REN and WEN together (or bad address with checking enabled)
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              RST,
  ram_access_ctrl_if.slave  ram_if
);

  if (!lat_legal(LAT)) begin : g_lat_check
    $error("ram_access_ctrl: LAT=%0d outside 1..%0d", LAT, RAM_LAT_MAX);
  end

  localparam ram_cnt_t CNT_LAST = ram_cnt_t'(LAT - 1);

  ram_cnt_t   cnt_q, cnt_d;
  logic       pvalid_q, pvalid_d;
  word_t      paddr_q, paddr_d;
  logic [1:0] pop_q, pop_d;

  logic              req;
  logic [1:0]        op;
  logic              is_new;
  ram_cnt_t          ecnt;
  logic              addr_err;
  ramstate_t         state;
  logic [ADDR_W-1:0] idx;
  logic              we;
  word_t             rdata;

  assign req = ram_if.ramREN | ram_if.ramWEN;
  assign op  = {ram_if.ramREN, ram_if.ramWEN};
  assign idx = ram_if.ramaddr[ADDR_W+1:2];

  // Any change of address or op restarts the count, so an abandoned
  // request never reaches ACCESS and never writes.
  assign is_new = !pvalid_q || (ram_if.ramaddr != paddr_q) || (op != pop_q);
  assign ecnt   = is_new ? '0 : cnt_q;

`ifdef RAM_ERROR_CHECK_EN
  assign addr_err = (ram_if.ramaddr[1:0] != 2'b00) ||
                    (ram_if.ramaddr[31:ADDR_W+2] != '0);
`else
  // Byte-offset and high address bits alias onto the word index.
  logic addr_bits_unused;
  assign addr_bits_unused = ^{ram_if.ramaddr[1:0], ram_if.ramaddr[31:ADDR_W+2]};
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state = FREE;
    if (RST || !req) begin
      state = FREE;
    end else if ((ram_if.ramREN && ram_if.ramWEN) || addr_err) begin
      state = ERROR;
    end else if (ecnt == CNT_LAST) begin
      state = ACCESS;
    end else begin
      state = BUSY;
    end
  end

  // Only BUSY carries progress forward; ACCESS clears so a request still
  // held afterwards starts a fresh access.
  always_comb begin
    cnt_d    = '0;
    pvalid_d = 1'b0;
    paddr_d  = paddr_q;
    pop_d    = pop_q;
    if (state == BUSY) begin
      cnt_d    = ecnt + 1'b1;
      pvalid_d = 1'b1;
      paddr_d  = ram_if.ramaddr;
      pop_d    = op;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      pvalid_q <= 1'b0;
      paddr_q  <= '0;
      pop_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pvalid_q <= pvalid_d;
      paddr_q  <= paddr_d;
      pop_q    <= pop_d;
    end
  end

  // state already reads FREE under RST, so no write can slip through.
  assign we = (state == ACCESS) && ram_if.ramWEN;

  ram_word_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (we),
    .waddr (idx),
    .wdata (ram_if.ramstore),
    .raddr (idx),
    .rdata (rdata)
  );

  assign ram_if.ramstate = state;
  assign ram_if.ramload  = (state == ACCESS) ? rdata : '0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl -- directed bench for ram_access_ctrl. Four instances
// with LAT=1..4 share clock and reset; each vector drives one instance for
// one cycle and checks its status and read data.
module tb_ram_access_ctrl;
  import cpu_types_pkg::*;

  localparam int N = 4;
`ifdef RAM_ERROR_CHECK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  logic      ren_v   [N];
  logic      wen_v   [N];
  word_t     addr_v  [N];
  word_t     store_v [N];
  word_t     ld_v    [N];
  ramstate_t st_v    [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_access_ctrl_if rif ();
    assign rif.ramREN   = ren_v[g];
    assign rif.ramWEN   = wen_v[g];
    assign rif.ramaddr  = addr_v[g];
    assign rif.ramstore = store_v[g];
    assign ld_v[g]      = rif.ramload;
    assign st_v[g]      = rif.ramstate;

    ram_access_ctrl #(
      .LAT    (g + 1),
      .ADDR_W (14)
    ) dut (
      .CLK    (clk),
      .RST    (rst),
      .ram_if (rif)
    );
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int        sel;
    logic      ren;
    logic      wen;
    word_t     addr;
    word_t     store;
    ramstate_t st;
    word_t     ld;
    bit        chk_ld;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int sel, logic ren, logic wen, word_t addr,
                              word_t store, ramstate_t st, word_t ld, bit chk_ld);
    vec_t v;
    v.sel = sel; v.ren = ren; v.wen = wen; v.addr = addr; v.store = store;
    v.st = st; v.ld = ld; v.chk_ld = chk_ld;
    vq.push_back(v);
  endfunction

  task automatic drive(int sel, logic ren, logic wen, word_t addr, word_t store);
    for (int i = 0; i < N; i++) begin
      ren_v[i] = 1'b0; wen_v[i] = 1'b0; addr_v[i] = '0; store_v[i] = '0;
    end
    ren_v[sel] = ren; wen_v[sel] = wen; addr_v[sel] = addr; store_v[sel] = store;
  endtask

  task automatic check(string name, int sel, ramstate_t st, word_t ld, bit chk_ld);
    checks++;
    if (st_v[sel] !== st || (chk_ld && ld_v[sel] !== ld)) begin
      errors++;
      $display("FAIL %s: lat=%0d state=%s want %s load=%h want %h",
               name, sel + 1, st_v[sel].name(), st.name(), ld_v[sel], ld);
    end
  endtask

  task automatic step(string name, int sel, logic ren, logic wen, word_t addr,
                      word_t store, logic rst_v, ramstate_t st, word_t ld, bit chk_ld);
    @(posedge clk);
    #1;
    rst = rst_v;
    drive(sel, ren, wen, addr, store);
    @(negedge clk);
    check(name, sel, st, ld, chk_ld);
  endtask

  initial begin
    // LAT=2: write then read back, pre-write read data on overwrite
    add(1, 0, 1, 32'h40, 32'hDEADBEEF, BUSY,   32'h0, 1);
    add(1, 0, 1, 32'h40, 32'hDEADBEEF, ACCESS, 32'h0, 0);
    add(1, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0, 1);
    add(1, 1, 0, 32'h40, 32'h0,        ACCESS, 32'hDEADBEEF, 1);
    add(1, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);
    add(1, 0, 1, 32'h40, 32'hCAFEF00D, BUSY,   32'h0, 1);
    add(1, 0, 1, 32'h40, 32'hCAFEF00D, ACCESS, 32'hDEADBEEF, 1);
    add(1, 1, 0, 32'h40, 32'h0,        BUSY,   32'h0, 1);
    add(1, 1, 0, 32'h40, 32'h0,        ACCESS, 32'hCAFEF00D, 1);
    // misaligned and high-bit addresses: alias, or ERROR when checked
    add(1, 1, 0, 32'h42, 32'h0, ERR_CHK ? ERROR : BUSY, 32'h0, 1);
    add(1, 1, 0, 32'h42, 32'h0, ERR_CHK ? ERROR : ACCESS,
        ERR_CHK ? 32'h0 : 32'hCAFEF00D, 1);
    add(1, 1, 0, 32'h10040, 32'h0, ERR_CHK ? ERROR : BUSY, 32'h0, 1);
    add(1, 1, 0, 32'h10040, 32'h0, ERR_CHK ? ERROR : ACCESS,
        ERR_CHK ? 32'h0 : 32'hCAFEF00D, 1);
    add(1, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);
    // REN&WEN error: no write, count stays clear
    add(1, 0, 1, 32'h10, 32'h11112222, BUSY,   32'h0, 1);
    add(1, 0, 1, 32'h10, 32'h11112222, ACCESS, 32'h0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 32'h10, 32'h0BAD0BAD, ERROR, 32'h0, 1);
    add(1, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);
    add(1, 1, 0, 32'h10, 32'h0,        BUSY,   32'h0, 1);
    add(1, 1, 0, 32'h10, 32'h0,        ACCESS, 32'h11112222, 1);
    add(1, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);
    // LAT=1: zero-wait, back-to-back
    add(0, 0, 1, 32'h0, 32'hA0A0A0A0, ACCESS, 32'h0, 0);
    add(0, 0, 1, 32'h4, 32'hB1B1B1B1, ACCESS, 32'h0, 0);
    add(0, 1, 0, 32'h0, 32'h0,        ACCESS, 32'hA0A0A0A0, 1);
    add(0, 1, 0, 32'h4, 32'h0,        ACCESS, 32'hB1B1B1B1, 1);
    add(0, 1, 0, 32'h4, 32'h0,        ACCESS, 32'hB1B1B1B1, 1);
    add(0, 0, 0, 32'h0, 32'h0,        FREE,   32'h0, 1);
    // LAT=3: address change mid-write restarts, abandoned write drops
    add(2, 0, 1, 32'h80, 32'h80808080, BUSY,   32'h0, 1);
    add(2, 0, 1, 32'h80, 32'h80808080, BUSY,   32'h0, 1);
    add(2, 0, 1, 32'h80, 32'h80808080, ACCESS, 32'h0, 0);
    add(2, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);
    add(2, 0, 1, 32'h80, 32'h12345678, BUSY,   32'h0, 1);
    add(2, 0, 1, 32'h84, 32'h12345678, BUSY,   32'h0, 1);
    add(2, 0, 1, 32'h84, 32'h12345678, BUSY,   32'h0, 1);
    add(2, 0, 1, 32'h84, 32'h12345678, ACCESS, 32'h0, 0);
    add(2, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);
    add(2, 1, 0, 32'h80, 32'h0, BUSY,   32'h0, 1);
    add(2, 1, 0, 32'h80, 32'h0, BUSY,   32'h0, 1);
    add(2, 1, 0, 32'h80, 32'h0, ACCESS, 32'h80808080, 1);
    add(2, 1, 0, 32'h84, 32'h0, BUSY,   32'h0, 1);
    add(2, 1, 0, 32'h84, 32'h0, BUSY,   32'h0, 1);
    add(2, 1, 0, 32'h84, 32'h0, ACCESS, 32'h12345678, 1);
    add(2, 0, 0, 32'h0,  32'h0, FREE,   32'h0, 1);
    // LAT=4: seed 0x20 for the reset-abort sequence
    for (int i = 0; i < 3; i++) add(3, 0, 1, 32'h20, 32'h20202020, BUSY, 32'h0, 1);
    add(3, 0, 1, 32'h20, 32'h20202020, ACCESS, 32'h0, 0);
    add(3, 0, 0, 32'h0,  32'h0,        FREE,   32'h0, 1);

    // reset: status forced FREE even with requests held
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    step("rst_lat1_req", 0, 1, 0, 32'h0,  32'h0, 1, FREE, 32'h0, 1);
    step("rst_lat4_req", 3, 0, 1, 32'h20, 32'h5, 1, FREE, 32'h0, 1);

    foreach (vq[i]) begin
      step($sformatf("vec%0d", i), vq[i].sel, vq[i].ren, vq[i].wen, vq[i].addr,
           vq[i].store, 1'b0, vq[i].st, vq[i].ld, vq[i].chk_ld);
    end

    // LAT=4: reset mid-BUSY aborts the write, rerun starts from zero and
    // its ACCESS still shows the old contents
    step("abort_busy0", 3, 0, 1, 32'h20, 32'h55AA55AA, 0, BUSY, 32'h0, 1);
    step("abort_busy1", 3, 0, 1, 32'h20, 32'h55AA55AA, 0, BUSY, 32'h0, 1);
    step("abort_rst0",  3, 0, 1, 32'h20, 32'h55AA55AA, 1, FREE, 32'h0, 1);
    step("abort_rst1",  3, 0, 1, 32'h20, 32'h55AA55AA, 1, FREE, 32'h0, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("rerun_busy%0d", i), 3, 0, 1, 32'h20, 32'h55AA55AA, 0, BUSY, 32'h0, 1);
    step("rerun_access", 3, 0, 1, 32'h20, 32'h55AA55AA, 0, ACCESS, 32'h20202020, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("readback_busy%0d", i), 3, 1, 0, 32'h20, 32'h0, 0, BUSY, 32'h0, 1);
    step("readback_access", 3, 1, 0, 32'h20, 32'h0, 0, ACCESS, 32'h55AA55AA, 1);
    step("final_free", 3, 0, 0, 32'h0, 32'h0, 0, FREE, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
